uart_receiver: RTL and testbench
================================

// Module: uart_receiver
// PURPOSE
//   Serial UART receiver (8N1, LSB first); receive-side counterpart of the existing UART transmit path.
//   Samples rx mid-bit using a fixed clocks-per-bit divider.
//   Pushes each good byte into an RX FIFO through its write_en/din/full interface, for readback over AXI-Lite.
//   Flags framing and overrun errors as single-cycle pulses for the AXI-Lite status logic.
// PARAMETERS
//   CLKS_PER_BIT  868  clk cycles per UART bit (100 MHz / 115200); must be >= 4
//   DATA_WIDTH    8    data bits per frame
// PORTS
//   clk          in   1           single clock; all logic on posedge
//   reset_n      in   1           reset, synchronous, active-low
//   rx           in   1           asynchronous serial input, idle high
//   fifo_full    in   1           RX FIFO full flag
//   fifo_wr_en   out  1           one-cycle write strobe to RX FIFO
//   fifo_din     out  DATA_WIDTH  received byte, valid while fifo_wr_en=1
//   frame_err    out  1           one-cycle pulse: stop bit sampled 0
//   overrun_err  out  1           one-cycle pulse: good byte dropped, FIFO full
//   busy         out  1           1 whenever state != IDLE
// BEHAVIOUR
// - Reset:
//   - reset_n=0 at a clk edge -> state IDLE; counters = 0; shift reg = 0.
//   - Synchronizer flops = 1.
//   - Outputs: fifo_wr_en=0, fifo_din=0, frame_err=0, overrun_err=0, busy=0.
//   - Reset mid-frame discards the partial byte; no write is issued.
// - Input: rx passes through a 2-flop synchronizer (rx_s); logic uses only rx_s.
// - States: IDLE, START, DATA, STOP, BREAK.
//   - Cycle counter clk_cnt, $clog2(CLKS_PER_BIT) bits.
//   - Bit index bit_idx, 0..DATA_WIDTH-1.
// - Timing: T0 = first cycle rx_s=0 seen in IDLE.
// - IDLE: on rx_s=0 -> START, clk_cnt=0.
// - START: at clk_cnt == CLKS_PER_BIT/2-1 (cycle T0+CLKS_PER_BIT/2), sample rx_s.
//   - rx_s=0 -> DATA, clk_cnt=0, bit_idx=0.
//   - rx_s=1 -> IDLE (glitch rejected, no pulse).
// - DATA: at clk_cnt == CLKS_PER_BIT-1, shift rx_s into MSB (right shift) and reset clk_cnt.
//   - Bit i is sampled at T0+CLKS_PER_BIT/2+(i+1)*CLKS_PER_BIT.
//   - After bit DATA_WIDTH-1 -> STOP.
// - STOP: sample at clk_cnt == CLKS_PER_BIT-1.
//   - rx_s=1, fifo_full=0: next cycle fifo_wr_en=1 with fifo_din=byte; -> IDLE.
//   - rx_s=1, fifo_full=1: next cycle overrun_err=1; no write; byte dropped; -> IDLE.
//   - rx_s=0: next cycle frame_err=1; no write; -> BREAK.
//   - fifo_full is checked only at the stop sample.
// - BREAK: wait for rx_s=1, then -> IDLE. A held-low line (break) never retriggers START.
// - fifo_din holds the last written byte until the next write.
// - Pulses are mutually exclusive; at most one pulse per frame.
// - Back-to-back frames: a start edge arriving the cycle after returning to IDLE is accepted.
//   - No idle gap is required beyond the stop bit.
// - Latency: stop sample to fifo_wr_en = 1 cycle.
//   - rx pin to sampling adds 2 cycles of synchronizer delay.
// TESTING (CLKS_PER_BIT=16)
//   1. Send 0xA5 with valid stop -> exactly one fifo_wr_en pulse, fifo_din=0xA5; no error pulses.
//   2. Drive rx low for 4 cycles, then high -> START aborts to IDLE; no wr_en or err; busy returns 0.
//   3. Send 0x3C with stop bit=0, hold rx low 40 cycles -> one frame_err pulse; no write.
//      busy stays 1 until rx returns high; only then may a new frame be received.
//   4. fifo_full=1 throughout frame 0x5A -> one overrun_err pulse; no write.
//      Then fifo_full=0 and send 0x11 -> write 0x11.
//   5. Send 0x00 then 0xFF back-to-back (no idle bits) -> two writes, 0x00 then 0xFF.
//   6. Assert reset_n=0 for 1 cycle during bit 3 of 0x77, keep rx high afterwards -> all outputs 0, IDLE.
//      No write; next frame 0x42 is received correctly.

Source files
------------

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: mid-bit sampling with a fixed divider, good bytes go to the RX FIFO,
// framing and overrun errors are reported as single-cycle pulses.
module uart_receiver #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned DATA_WIDTH   = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  rx,
    input  logic                  fifo_full,
    output logic                  fifo_wr_en,
    output logic [DATA_WIDTH-1:0] fifo_din,
    output logic                  frame_err,
    output logic                  overrun_err,
    output logic                  busy
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_WIDTH - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_STOP  = 3'd3;
    localparam logic [2:0] S_BREAK = 3'd4;

    logic                  rx_meta;
    logic                  rx_s;
    logic [2:0]            state;
    logic [2:0]            state_n;
    logic [CNT_W-1:0]      clk_cnt;
    logic [CNT_W-1:0]      clk_cnt_n;
    logic [IDX_W-1:0]      bit_idx;
    logic [IDX_W-1:0]      bit_idx_n;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic [DATA_WIDTH-1:0] shift_n;
    logic [DATA_WIDTH-1:0] din_n;
    logic                  wr_en_n;
    logic                  frame_err_n;
    logic                  overrun_n;

    // State, datapath and registered outputs; sync flops reset to the idle-high line level
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rx_meta     <= 1'b1;
            rx_s        <= 1'b1;
            state       <= S_IDLE;
            clk_cnt     <= '0;
            bit_idx     <= '0;
            shift_reg   <= '0;
            fifo_wr_en  <= 1'b0;
            fifo_din    <= '0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
            busy        <= 1'b0;
        end else begin
            rx_meta     <= rx;
            rx_s        <= rx_meta;
            state       <= state_n;
            clk_cnt     <= clk_cnt_n;
            bit_idx     <= bit_idx_n;
            shift_reg   <= shift_n;
            fifo_wr_en  <= wr_en_n;
            fifo_din    <= din_n;
            frame_err   <= frame_err_n;
            overrun_err <= overrun_n;
            busy        <= (state_n != S_IDLE);
        end
    end

    // Next-state and output decode
    always_comb begin
        state_n     = state;
        clk_cnt_n   = clk_cnt;
        bit_idx_n   = bit_idx;
        shift_n     = shift_reg;
        din_n       = fifo_din;
        wr_en_n     = 1'b0;
        frame_err_n = 1'b0;
        overrun_n   = 1'b0;

        case (state)
            S_IDLE: begin
                if (!rx_s) begin
                    state_n   = S_START;
                    clk_cnt_n = '0;
                end
            end
            S_START: begin
                if (clk_cnt == HALF_LAST) begin
                    clk_cnt_n = '0;
                    if (!rx_s) begin
                        state_n   = S_DATA;
                        bit_idx_n = '0;
                    end else begin
                        state_n = S_IDLE;
                    end
                end else begin
                    clk_cnt_n = clk_cnt + CNT_W'(1);
                end
            end
            S_DATA: begin
                if (clk_cnt == BIT_LAST) begin
                    clk_cnt_n = '0;
                    shift_n   = {rx_s, shift_reg[DATA_WIDTH-1:1]};
                    if (bit_idx == IDX_LAST) begin
                        state_n = S_STOP;
                    end else begin
                        bit_idx_n = bit_idx + IDX_W'(1);
                    end
                end else begin
                    clk_cnt_n = clk_cnt + CNT_W'(1);
                end
            end
            S_STOP: begin
                if (clk_cnt == BIT_LAST) begin
                    clk_cnt_n = '0;
                    if (rx_s) begin
                        state_n = S_IDLE;
                        if (fifo_full) begin
                            overrun_n = 1'b1;
                        end else begin
                            wr_en_n = 1'b1;
                            din_n   = shift_reg;
                        end
                    end else begin
                        frame_err_n = 1'b1;
                        state_n     = S_BREAK;
                    end
                end else begin
                    clk_cnt_n = clk_cnt + CNT_W'(1);
                end
            end
            // A held-low line must return high before a new start edge is accepted
            S_BREAK: begin
                if (rx_s) begin
                    state_n = S_IDLE;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_receiver.sv
// Bench for uart_receiver: frame table, hand-written corner sequences and random frames,
// all checked against an event scoreboard predicted from frame-level rules.
module tb_uart_receiver;

    localparam int unsigned C  = 16;
    localparam int unsigned DW = 8;

    localparam logic [1:0] EV_WR = 2'd1;
    localparam logic [1:0] EV_FE = 2'd2;
    localparam logic [1:0] EV_OV = 2'd3;

    logic          clk;
    logic          reset_n;
    logic          rx;
    logic          fifo_full;
    logic          fifo_wr_en;
    logic [DW-1:0] fifo_din;
    logic          frame_err;
    logic          overrun_err;
    logic          busy;

    int tests;
    int failed;

    logic [9:0]    got_q[$];
    logic [9:0]    exp_q[$];
    logic [DW-1:0] last_wr;

    typedef struct {
        logic [7:0] data;
        logic       stop_ok;
        logic       full;
        int         gap_bits;
        logic [1:0] exp_kind;
        logic [7:0] exp_data;
    } vec_t;

    vec_t vecs[6];

    uart_receiver #(.CLKS_PER_BIT(C), .DATA_WIDTH(DW)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .rx          (rx),
        .fifo_full   (fifo_full),
        .fifo_wr_en  (fifo_wr_en),
        .fifo_din    (fifo_din),
        .frame_err   (frame_err),
        .overrun_err (overrun_err),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Event monitor, sampled on the falling edge
    always @(negedge clk) begin
        int n;
        n = int'(fifo_wr_en) + int'(frame_err) + int'(overrun_err);
        if (n > 0) begin
            tests++;
            if (n > 1) begin
                failed++;
                $display("FAIL pulse_exclusive: %0d pulses in one cycle, required 1", n);
            end
        end
        if (fifo_wr_en)  got_q.push_back({EV_WR, fifo_din});
        if (frame_err)   got_q.push_back({EV_FE, 8'h00});
        if (overrun_err) got_q.push_back({EV_OV, 8'h00});
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive(input logic level, input int n);
        rx = level;
        idle(n);
    endtask

    // Frame-level reference: stop bit decides framing, then FIFO full decides write vs overrun
    task automatic expect_frame(input logic [7:0] d, input logic stop_ok, input logic full);
        if (!stop_ok)  exp_q.push_back({EV_FE, 8'h00});
        else if (full) exp_q.push_back({EV_OV, 8'h00});
        else           exp_q.push_back({EV_WR, d});
    endtask

    // Full serial frame; a bad stop bit is followed by a 40-cycle break and one high bit time
    task automatic send_frame(input logic [7:0] d, input logic stop_ok, input logic full);
        fifo_full = full;
        drive(1'b0, C);
        for (int i = 0; i < DW; i++) drive(d[i], C);
        drive(stop_ok, C);
        if (!stop_ok) begin
            drive(1'b0, 40);
            drive(1'b1, C);
        end
    endtask

    task automatic check_events(input string name);
        int n;
        tests++;
        if (got_q.size() != exp_q.size()) begin
            failed++;
            $display("FAIL %s_count: got %0d events, required %0d", name, got_q.size(), exp_q.size());
        end
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) check({name, "_event"}, 32'(got_q[i]), 32'(exp_q[i]));
        foreach (exp_q[i]) if (exp_q[i][9:8] == EV_WR) last_wr = exp_q[i][7:0];
        check({name, "_din_hold"}, 32'(fifo_din), 32'(last_wr));
        check({name, "_busy_idle"}, 32'(busy), 32'd0);
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        tests     = 0;
        failed    = 0;
        last_wr   = '0;
        rx        = 1'b1;
        fifo_full = 1'b0;
        reset_n   = 1'b0;

        vecs[0] = '{8'hA5, 1'b1, 1'b0, 1, EV_WR, 8'hA5};
        vecs[1] = '{8'h5A, 1'b1, 1'b1, 0, EV_OV, 8'h00};
        vecs[2] = '{8'h11, 1'b1, 1'b0, 1, EV_WR, 8'h11};
        vecs[3] = '{8'h00, 1'b1, 1'b0, 0, EV_WR, 8'h00};
        vecs[4] = '{8'hFF, 1'b1, 1'b0, 1, EV_WR, 8'hFF};
        vecs[5] = '{8'h3C, 1'b0, 1'b1, 1, EV_FE, 8'h00};

        idle(3);
        check("rst_wr_en", 32'(fifo_wr_en), 32'd0);
        check("rst_din", 32'(fifo_din), 32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        check("rst_overrun", 32'(overrun_err), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        reset_n = 1'b1;
        idle(5);

        // Table: single write, overrun then back-to-back write, 0x00/0xFF back-to-back, framing with full set
        for (int v = 0; v < 6; v++) begin
            send_frame(vecs[v].data, vecs[v].stop_ok, vecs[v].full);
            exp_q.push_back({vecs[v].exp_kind, vecs[v].exp_data});
            if (vecs[v].gap_bits > 0) begin
                fifo_full = 1'b0;
                drive(1'b1, vecs[v].gap_bits * C);
                check_events($sformatf("vec%0d", v));
            end
        end

        // Short start glitch is rejected
        drive(1'b0, 4);
        check("glitch_busy", 32'(busy), 32'd1);
        drive(1'b1, 3 * C);
        check_events("glitch");

        // Bad stop bit with a held-low break; busy persists until the line goes high
        fifo_full = 1'b0;
        drive(1'b0, C);
        for (int i = 0; i < DW; i++) drive(1'(8'h3C >> i), C);
        drive(1'b0, C + 40);
        check("break_busy", 32'(busy), 32'd1);
        check("break_one_fe", 32'(got_q.size()), 32'd1);
        drive(1'b1, 4);
        check("break_release", 32'(busy), 32'd0);
        exp_q.push_back({EV_FE, 8'h00});
        idle(12 * C);
        check_events("break");

        // Reset during bit 3 of 0x77 drops the partial byte and clears the held data
        drive(1'b0, C);
        for (int i = 0; i < 3; i++) drive(1'(8'h77 >> i), C);
        drive(1'b0, C / 2);
        reset_n = 1'b0;
        rx      = 1'b1;
        idle(1);
        reset_n = 1'b1;
        check("midrst_wr_en", 32'(fifo_wr_en), 32'd0);
        check("midrst_din", 32'(fifo_din), 32'd0);
        check("midrst_frame_err", 32'(frame_err), 32'd0);
        check("midrst_overrun", 32'(overrun_err), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        last_wr = '0;
        idle(12 * C);
        check_events("midrst");
        send_frame(8'h42, 1'b1, 1'b0);
        expect_frame(8'h42, 1'b1, 1'b0);
        drive(1'b1, C);
        check_events("after_rst");

        // Random frames with random stop validity, FIFO state and idle gaps
        for (int f = 0; f < 40; f++) begin
            logic [7:0] d;
            logic       s;
            logic       full;
            int         gap;
            d    = 8'($urandom);
            s    = ($urandom_range(7) != 0);
            full = ($urandom_range(3) == 0);
            gap  = (f == 39) ? 2 : int'($urandom_range(2));
            send_frame(d, s, full);
            expect_frame(d, s, full);
            if (gap > 0) begin
                fifo_full = 1'b0;
                drive(1'b1, gap * C);
                check_events($sformatf("rand%0d", f));
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
